// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array stream front end.
package systolic_pkg;
  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 4;
  localparam int RES_W_DEF  = 11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_RUN, ST_DRAIN
  } state_t;

  typedef logic [DATA_W_DEF-1:0] op_elem_t;
  typedef logic [RES_W_DEF-1:0]  res_elem_t;

  // width of a row-major element index over an n x n matrix
  function automatic int idx_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction
endpackage

// File: rtl/systolic_stream_frontend_if.sv
// Operand-in / result-out valid-ready streams of the systolic front end.
interface systolic_stream_frontend_if #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 11
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [RES_W-1:0]  out_data_o;
  logic              out_last_o;

  modport master (output in_valid_i, in_data_i, out_ready_i,
                  input  in_ready_o, out_valid_o, out_data_o, out_last_o);
  modport slave  (input  in_valid_i, in_data_i, out_ready_i,
                  output in_ready_o, out_valid_o, out_data_o, out_last_o);
endinterface

// File: rtl/systolic_stream_frontend_result_serializer.sv
// Captures the array result matrix and streams it out row-major with last.
module result_serializer import systolic_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int RES_W = RES_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        capture,
  input  logic [N*N-1:0][RES_W-1:0]   res,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [RES_W-1:0]            out_data,
  output logic                        out_last,
  output logic                        drain_done
);
  localparam int IDX_W = idx_w(N);

  logic [N*N-1:0][RES_W-1:0] cap_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      active_q;
  logic                      hs, at_last;

  assign hs      = active_q & out_ready;
  assign at_last = idx_q == IDX_W'(N * N - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (capture) begin
      cap_q    <= res;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (hs) begin
      idx_q <= at_last ? '0 : idx_q + 1'b1;
      if (at_last) active_q <= 1'b0;
    end
  end

  // data is only meaningful while valid; keep the bus quiet otherwise
  assign out_valid  = active_q;
  assign out_data   = active_q ? cap_q[idx_q] : '0;
  assign out_last   = active_q & at_last;
  assign drain_done = hs & at_last;
endmodule

// File: rtl/systolic_stream_frontend.sv
// Stream front end for the N x N systolic multiplier: load A/B, run, drain.
// Optional RUN watchdog compiled in with SYSARR_WATCHDOG_EN.
module systolic_stream_frontend import systolic_pkg::*; #(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
`ifdef SYSARR_WATCHDOG_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  systolic_stream_frontend_if.slave         s,
  output logic                              array_rst_o,
  output logic [N-1:0][N-1:0][DATA_W-1:0]   mat_a_o,
  output logic [N-1:0][N-1:0][DATA_W-1:0]   mat_b_o,
  input  logic [N-1:0][N-1:0][RES_W-1:0]    res_i,
  input  logic                              done_i,
  output logic                              busy_o,
  output logic                              err_o
);
  localparam int IDX_W = idx_w(N);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q;
  logic [N*N-1:0][DATA_W-1:0] a_q, b_q;
  logic in_hs, last_in, run_armed, capture, timeout, drain_done;

  assign s.in_ready_o = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign in_hs        = s.in_valid_i & s.in_ready_o;
  assign last_in      = idx_q == IDX_W'(N * N - 1);
  assign capture      = (state_q == ST_RUN) & run_armed & done_i;
  assign array_rst_o  = state_q != ST_RUN;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_LOAD_A);
  assign mat_a_o      = a_q;
  assign mat_b_o      = b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_LOAD_A;
      ST_LOAD_A: if (in_hs && last_in) state_d = ST_LOAD_B;
      ST_LOAD_B: if (in_hs && last_in) state_d = ST_RUN;
      ST_RUN:    if (capture) state_d = ST_DRAIN;
                 else if (timeout) state_d = ST_LOAD_A;
      ST_DRAIN:  if (drain_done) state_d = ST_LOAD_A;
      default:   state_d = ST_IDLE;
    endcase
  end

  // one index walks A then B; the wrap on the last beat lines up with the phase change
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (in_hs) begin
      if (state_q == ST_LOAD_A) a_q[idx_q] <= s.in_data_i;
      else                      b_q[idx_q] <= s.in_data_i;
      idx_q <= last_in ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SYSARR_WATCHDOG_EN
  localparam int RC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RC_W-1:0] run_cnt_q;
  logic            err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      run_cnt_q <= (state_q == ST_RUN) ? run_cnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  // done arriving in the final allowed cycle still wins over the timeout
  assign run_armed = run_cnt_q != '0;
  assign timeout   = (state_q == ST_RUN) && !capture &&
                     (run_cnt_q == RC_W'(TIMEOUT_CYCLES - 1));
  assign err_o     = err_q;
`else
  logic run_armed_q;

  // done is ignored during the first RUN cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) run_armed_q <= 1'b0;
    else       run_armed_q <= state_q == ST_RUN;
  end

  assign run_armed = run_armed_q;
  assign timeout   = 1'b0;
  assign err_o     = 1'b0;
`endif

  result_serializer #(.N(N), .RES_W(RES_W)) u_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .capture    (capture),
    .res        (res_i),
    .out_ready  (s.out_ready_i),
    .out_valid  (s.out_valid_o),
    .out_data   (s.out_data_o),
    .out_last   (s.out_last_o),
    .drain_done (drain_done)
  );
endmodule

// File: tb/tb_systolic_stream_frontend.sv
// Randomized bench for systolic_stream_frontend with a matrix-level reference model.
module tb_systolic_stream_frontend;
  localparam int N = 4, DW = 4, RW = 11, NN = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_stream_frontend_if #(.DATA_W(DW), .RES_W(RW)) s();
  logic                          array_rst, done, busy, err;
  logic [N-1:0][N-1:0][DW-1:0]   mat_a, mat_b;
  logic [N-1:0][N-1:0][RW-1:0]   res;

  systolic_stream_frontend #(.N(N), .DATA_W(DW), .RES_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .s(s), .array_rst_o(array_rst),
    .mat_a_o(mat_a), .mat_b_o(mat_b), .res_i(res), .done_i(done),
    .busy_o(busy), .err_o(err));

  int total = 0, bad = 0;
  int ea[NN], eb[NN], pa[NN], pb[NN], exq[NN];
  int lat = 3, rmode = 0, beat_ix = 0, stall_left = 0, cyc = 0;
  bit hang = 1'b0;
  int run_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic bail(input string tag);
    chk(tag, 64'd0, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "stopped on %s", tag);
  endtask

  function automatic logic [63:0] pack(input int m[NN]);
    logic [63:0] v = '0;
    for (int i = 0; i < NN; i++) v[i*DW +: DW] = DW'(m[i]);
    return v;
  endfunction

  // array stand-in: multiplies whatever sits on the operand buses
  function automatic logic [N-1:0][N-1:0][RW-1:0] mul(input logic [N-1:0][N-1:0][DW-1:0] a,
                                                       input logic [N-1:0][N-1:0][DW-1:0] b);
    logic [N-1:0][N-1:0][RW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          r[i][j] = r[i][j] + RW'(a[i][k]) * RW'(b[k][j]);
    return r;
  endfunction

  always_comb res = mul(mat_a, mat_b);

  // done asserts lat cycles into RUN; random noise while the array is held in reset
  always @(posedge clk) begin
    #2;
    if (array_rst) begin
      run_cyc = 0;
      done = !hang && ($urandom_range(0, 3) == 0);
    end else begin
      run_cyc++;
      done = !hang && (run_cyc >= lat);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rmode)
      0: s.out_ready_i = 1'b1;
      1: if (beat_ix == 6 && stall_left > 0) begin
           s.out_ready_i = 1'b0;
           stall_left--;
         end else s.out_ready_i = cyc[0];
      default: s.out_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic feed(input int m[NN]);
    for (int i = 0; i < NN; i++) begin
      int guard = 0;
      while ($urandom_range(0, 2) == 0) begin
        s.in_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      s.in_valid_i = 1'b1;
      s.in_data_i  = DW'(m[i]);
      @(negedge clk);
      while (!s.in_ready_o) begin
        guard++;
        if (guard > 50) bail("in_ready_timeout");
        @(negedge clk);
      end
      chk("no_out_in_load", s.out_valid_o, 0);
      @(posedge clk); #1;
    end
    s.in_valid_i = 1'b0;
  endtask

  task automatic run_job(input int mode, input int abort_at);
    int k = 1, beat = 0, dcyc = 0, want_k;
    bit held = 1'b0;
    logic [RW-1:0] hd;
    logic hl;
    rmode = mode; stall_left = 5; beat_ix = 0;
    lat = $urandom_range(1, 6);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exq[r*N+c] = 0;
        for (int x = 0; x < N; x++) exq[r*N+c] += ea[r*N+x] * eb[x*N+c];
      end
    chk("hold_old_a", mat_a, pack(pa));
    chk("hold_old_b", mat_b, pack(pb));
    feed(ea);
    feed(eb);
    s.in_valid_i = 1'b1; s.in_data_i = DW'($urandom);
    @(negedge clk);
    chk("arst_fall", array_rst, 0);
    chk("mat_a_bus", mat_a, pack(ea));
    chk("mat_b_bus", mat_b, pack(eb));
    chk("busy_run", busy, 1);
    while (!s.out_valid_o) begin
      chk("no_ready_run", s.in_ready_o, 0);
      if (k > 100) bail("done_timeout");
      @(posedge clk); #1; s.in_data_i = DW'($urandom);
      @(negedge clk); k++;
    end
    want_k = (lat > 2 ? lat : 2) + 1;
    chk("valid_latency", k, want_k);
    chk("arst_drain", array_rst, 1);
    while (beat < NN) begin
      dcyc++;
      if (dcyc > 400) bail("drain_timeout");
      chk("drain_valid", s.out_valid_o, 1);
      chk("no_ready_drain", s.in_ready_o, 0);
      if (held) begin
        chk("stall_data", s.out_data_o, hd);
        chk("stall_last", s.out_last_o, hl);
      end
      if (beat == abort_at) begin
        rst = 1'b1; #1;
        chk("abort_valid", s.out_valid_o, 0);
        chk("abort_data", s.out_data_o, 0);
        chk("abort_last", s.out_last_o, 0);
        chk("abort_arst", array_rst, 1);
        chk("abort_busy", busy, 0);
        chk("abort_mats", {mat_a, mat_b}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0; s.in_valid_i = 1'b0; beat_ix = 0;
        pa = '{default: 0}; pb = '{default: 0};
        return;
      end
      if (s.out_ready_i) begin
        chk("out_data", s.out_data_o, exq[beat]);
        chk("out_last", s.out_last_o, beat == NN - 1);
        beat++; beat_ix = beat; held = 1'b0;
      end else begin
        held = 1'b1; hd = s.out_data_o; hl = s.out_last_o;
      end
      @(posedge clk); #1;
      s.in_valid_i = (beat < NN); s.in_data_i = DW'($urandom);
      @(negedge clk);
    end
    if (mode == 0) chk("drain_cycles", dcyc, NN);
    chk("post_valid", s.out_valid_o, 0);
    chk("post_ready", s.in_ready_o, 1);
    chk("post_busy", busy, 0);
    pa = ea; pb = eb;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    bail("global_timeout");
  end

  initial begin
    int m0[NN] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15};
    s.in_valid_i = 1'b0; s.in_data_i = '0;
    pa = '{default: 0}; pb = '{default: 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", s.in_ready_o, 0);
    chk("rst_out_valid", s.out_valid_o, 0);
    chk("rst_out_data", s.out_data_o, 0);
    chk("rst_out_last", s.out_last_o, 0);
    chk("rst_arst", array_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mats", {mat_a, mat_b}, 128'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", s.in_ready_o, 0);
    @(negedge clk);
    chk("loada_ready", s.in_ready_o, 1);
    chk("loada_busy", busy, 0);
    @(posedge clk); #1;

    ea = m0; eb = m0;
    run_job(0, -1);
    for (int i = 0; i < NN; i++) ea[i] = (i / N == i % N) ? 1 : 0;
    eb = m0;
    run_job(1, -1);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < NN; i++) begin
        ea[i] = $urandom_range(0, 15);
        eb[i] = $urandom_range(0, 15);
      end
      run_job(j == 2 ? 0 : 2, j == 0 ? 4 : -1);
    end
    chk("err_clear", err, 0);

`ifdef SYSARR_WATCHDOG_EN
    begin
      int rc = 0;
      hang = 1'b1;
      feed(ea);
      feed(eb);
      @(negedge clk);
      while (!array_rst) begin
        rc++;
        chk("wd_no_out", s.out_valid_o, 0);
        if (rc > 200) bail("wd_timeout");
        @(negedge clk);
      end
      chk("wd_cycles", rc, 64);
      chk("wd_err", err, 1);
      chk("wd_ready", s.in_ready_o, 1);
      chk("wd_out_valid", s.out_valid_o, 0);
      hang = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_stream_frontend.md
# systolic_stream_frontend

Streaming host-side front end for the N×N systolic matrix multiplier.
- Accepts operand matrices A then B as a valid/ready element stream and presents them as parallel matrix buses to the array.
- Holds the array in reset while loading, releases it to compute, then captures the result matrix on `done` and serialises it out on a second valid/ready stream.
- Sits between the host/DMA streams and the systolic array instance.

## Interface
- `N`, 4 — matrix dimension.
- `DATA_W`, 4 — operand element width, unsigned.
- `RES_W`, 11 — result element width, unsigned; must satisfy RES_W ≥ 2·DATA_W + clog2(N).
- `TIMEOUT_CYCLES`, 64 — watchdog limit in RUN; used only when the watchdog is compiled in.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `in_valid_i`  in  1  operand beat valid.
- `in_ready_o`  out  1  operand beat accepted when valid & ready.
- `in_data_i`  in  DATA_W  operand element.
- `out_valid_o`  out  1  result beat valid.
- `out_ready_i`  in  1  downstream ready.
- `out_data_o`  out  RES_W  result element.
- `out_last_o`  out  1  marks element [N-1][N-1].
- `array_rst_o`  out  1  reset to the systolic array.
- `mat_a_o`  out  N×N×DATA_W  operand A to the array.
- `mat_b_o`  out  N×N×DATA_W  operand B to the array.
- `res_i`  in  N×N×RES_W  array result matrix.
- `done_i`  in  1  array completion flag.
- `busy_o`  out  1  high in every state except IDLE and LOAD_A.
- `err_o`  out  1  watchdog error, sticky until reset.

## Operation
- FSM states: IDLE → LOAD_A → LOAD_B → RUN → DRAIN → LOAD_A. IDLE is the reset state; it exits to LOAD_A unconditionally after one cycle.
- LOAD_A / LOAD_B:
  - `in_ready_o` = 1.
  - Each handshake writes element [row][col] in row-major order. A single index counter (0..N·N-1) is shared by both phases and wraps to 0 at each phase change.
  - The handshake on index N·N-1 moves LOAD_A → LOAD_B and LOAD_B → RUN.
- RUN:
  - `array_rst_o` = 0 and `in_ready_o` = 0.
  - `done_i` is ignored in the first RUN cycle.
  - From the second RUN cycle on, `done_i` = 1 latches all of `res_i` into capture registers and moves to DRAIN.
- DRAIN:
  - `array_rst_o` = 1.
  - `out_valid_o` = 1; `out_data_o` = capture[idx], row-major.
  - The index advances on each out handshake. `out_last_o` = 1 when idx = N·N-1.
  - The final handshake moves to LOAD_A.
- `array_rst_o` = 1 in IDLE, LOAD_A, LOAD_B and DRAIN.
- Once LOAD_A restarts, `mat_a_o` and `mat_b_o` hold their old values until they are overwritten element by element.
- Input beats presented outside LOAD states are not accepted; they are held upstream.

## Timing
- Reset values:
  - `in_ready_o` = 0, `out_valid_o` = 0, `out_data_o` = 0, `out_last_o` = 0.
  - `array_rst_o` = 1, `busy_o` = 0, `err_o` = 0.
  - `mat_a_o`, `mat_b_o` and the capture registers all = 0; index = 0; state = IDLE.
- `in_ready_o` first rises in the second cycle after reset deassertion.
- `array_rst_o` falls in the cycle after the last B handshake.
- `out_valid_o` rises in the cycle after `done_i` is sampled high.
- Out path, minimum: one beat per cycle with `out_ready_i` held high, i.e. N·N cycles for DRAIN.
- Out path, backpressure: `out_data_o` and `out_last_o` stay stable while valid & !ready.
- Throughput with no stalls: 2·N·N + array latency + N·N + 1 cycles per job.
- Reset asserted in any state, including mid-DRAIN or mid-LOAD, returns to IDLE immediately. Partial data is discarded and no further out beat is emitted.
- `done_i` high outside RUN has no effect.

## Configuration
- `SYSARR_WATCHDOG_EN` defined:
  - A RUN-cycle counter is compiled in.
  - If `done_i` has not been sampled by cycle TIMEOUT_CYCLES of RUN, `err_o` is set, `array_rst_o` = 1, and the FSM goes to LOAD_A with no DRAIN.
  - `err_o` is sticky until reset.
- `SYSARR_WATCHDOG_EN` undefined:
  - No counter; RUN waits indefinitely.
  - `err_o` is tied 0.

## Structure
- Shared package `systolic_pkg`:
  - FSM state enum.
  - Default N/DATA_W/RES_W constants.
  - Element typedefs for operands and results.
  - Function computing index width clog2(N·N).
- One natural sub-module, `result_serializer`: capture registers, out-index counter, and valid/ready/last generation. The top keeps the FSM, load path and watchdog.

## Test plan
- Load A = rows {0,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,15} and the same values for B, then run against the array → first out row 89, 98, 107, 112; 16 beats; `out_last_o` only on beat 16.
- A = identity, B = the matrix above → output stream equals B row-major.
- Toggle `out_ready_i` every other cycle, plus a 5-cycle stall on beat 7 → every beat is delivered exactly once and in order, with data stable during stalls.
- Gap `in_valid_i` randomly during LOAD, and present input during RUN/DRAIN → no beats are accepted outside LOAD, and the operand buses are correct when `array_rst_o` falls.
- Assert `rst_i` on DRAIN beat 5 → all outputs return to reset values at once; the next job streams 16 correct beats.
- With `SYSARR_WATCHDOG_EN` and `done_i` tied 0 → `err_o` rises after 64 RUN cycles, no out beats are produced, and `in_ready_o` is 1 in the following cycle.
